// File: rtl/golomb_best_ruler_recorder.sv
// Best-ruler recorder: latches each accepted Golomb ruler, tightens the shared length limit, streams the marks out, and flags exhaustion.
// Latency: 1 cycle from an accepted success to the limit update and to the first out_valid beat; the drain takes NUMPOSITIONS+1 beats minimum.
// Backpressure: out_mark, out_last and the beat index hold while out_ready=0; hold stays high until the last beat is taken, and a success seen meanwhile sets dropped.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   success, val            leaf reports a ruler of length val this cycle
//   enabled                 active mark level, 0 = search exhausted
//   marks_in                packed marks, m[0] in the most significant 9 bits
//   limit, hold             feedback to the mark counters
//   out_valid/ready/mark/last  mark stream, out_last on m[NUMPOSITIONS]
//   solutions, dropped, done   status outputs
module golomb_best_ruler_recorder #(
    parameter int NUMPOSITIONS = 5,
    parameter int INITLIMIT    = 500
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            success,
    input  logic [8:0]                      val,
    input  logic [6:0]                      enabled,
    input  logic [((NUMPOSITIONS+1)*9):1]   marks_in,
    output logic [8:0]                      limit,
    output logic                            hold,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [8:0]                      out_mark,
    output logic                            out_last,
    output logic [15:0]                     solutions,
    output logic                            dropped,
    output logic                            done
);

    localparam int IDXW = (NUMPOSITIONS > 0) ? $clog2(NUMPOSITIONS + 1) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMPOSITIONS);

    typedef enum logic [1:0] {SEARCH, DRAIN, DONE} state_t;

    state_t          r_state;
    logic [8:0]      r_best [0:NUMPOSITIONS];
    logic [IDXW-1:0] r_idx;
    logic [8:0]      r_limit;
    logic            r_hold;
    logic            r_out_valid;
    logic [8:0]      r_out_mark;
    logic            r_out_last;
    logic [15:0]     r_solutions;
    logic            r_dropped;
    logic            r_done;
    // Exhaustion seen while a capture is in flight; decides where the drain ends up.
    logic            r_exh;

    logic [8:0]      w_cap [0:NUMPOSITIONS];
    logic            w_accept;
    logic            w_fire;
    logic            w_exh_now;
    logic [IDXW-1:0] w_idx_nxt;

    // The last mark is taken from val: the leaf value is authoritative, the
    // corresponding field of marks_in is not used.
    always_comb begin
        for (int k = 0; k <= NUMPOSITIONS; k++) begin
            w_cap[k] = '0;
        end
        for (int k = 0; k < NUMPOSITIONS; k++) begin
            w_cap[k] = marks_in[(NUMPOSITIONS + 1 - k) * 9 -: 9];
        end
        w_cap[NUMPOSITIONS] = val;
    end

    // val != 0 keeps val-1 from wrapping the limit.
    assign w_accept  = success && (val != 9'd0) && (val <= r_limit);
    assign w_fire    = r_out_valid && out_ready;
    assign w_exh_now = (enabled == 7'd0);
    assign w_idx_nxt = r_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= SEARCH;
            for (int k = 0; k <= NUMPOSITIONS; k++) begin
                r_best[k] <= '0;
            end
            r_idx       <= '0;
            r_limit     <= 9'(INITLIMIT);
            r_hold      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mark  <= '0;
            r_out_last  <= 1'b0;
            r_solutions <= '0;
            r_dropped   <= 1'b0;
            r_done      <= 1'b0;
            r_exh       <= 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    // A ruler found in the same cycle as exhaustion still gets
                    // recorded; r_exh carries the exhaustion through the drain.
                    if (w_accept) begin
                        for (int k = 0; k <= NUMPOSITIONS; k++) begin
                            r_best[k] <= w_cap[k];
                        end
                        r_limit <= val - 9'd1;
                        if (r_solutions != 16'hFFFF) begin
                            r_solutions <= r_solutions + 16'd1;
                        end
                        r_hold      <= 1'b1;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_mark  <= w_cap[0];
                        r_out_last  <= (NUMPOSITIONS == 0);
                        r_exh       <= w_exh_now;
                        r_state     <= DRAIN;
                    end else if (w_exh_now) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DRAIN: begin
                    if (success) begin
                        r_dropped <= 1'b1;
                    end
                    if (w_exh_now) begin
                        r_exh <= 1'b1;
                    end
                    if (w_fire) begin
                        if (r_idx == LAST_IDX) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_hold      <= 1'b0;
                            r_idx       <= '0;
                            if (r_exh || w_exh_now) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_state <= SEARCH;
                            end
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_out_mark <= r_best[w_idx_nxt];
                            r_out_last <= (w_idx_nxt == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    r_hold      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b1;
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign limit     = r_limit;
    assign hold      = r_hold;
    assign out_valid = r_out_valid;
    assign out_mark  = r_out_mark;
    assign out_last  = r_out_last;
    assign solutions = r_solutions;
    assign dropped   = r_dropped;
    assign done      = r_done;

endmodule

// File: tb/tb_golomb_best_ruler_recorder.sv
// Testbench for golomb_best_ruler_recorder: directed scenarios followed by randomized traffic.
// Latency: outputs are compared 1 time unit after every rising edge against a queue-based reference.
// Backpressure: out_ready is randomized; expected beats wait in the reference queue until taken.
module tb_golomb_best_ruler_recorder;

    localparam int NP = 5;
    localparam int IL = 20;
    localparam int W  = (NP + 1) * 9;

    logic         clock = 1'b0;
    logic         reset;
    logic         success;
    logic [8:0]   val;
    logic [6:0]   enabled;
    logic [W:1]   marks_in;
    logic [8:0]   limit;
    logic         hold;
    logic         out_valid;
    logic         out_ready;
    logic [8:0]   out_mark;
    logic         out_last;
    logic [15:0]  solutions;
    logic         dropped;
    logic         done;

    golomb_best_ruler_recorder #(.NUMPOSITIONS(NP), .INITLIMIT(IL)) dut (
        .clock     (clock),
        .reset     (reset),
        .success   (success),
        .val       (val),
        .enabled   (enabled),
        .marks_in  (marks_in),
        .limit     (limit),
        .hold      (hold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mark  (out_mark),
        .out_last  (out_last),
        .solutions (solutions),
        .dropped   (dropped),
        .done      (done)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Reference: pending beats of the ruler being streamed plus status counters.
    int q_mark[$];
    int q_last[$];
    int m_limit;
    int m_sol;
    int m_drop;
    int m_done;
    int m_exh;
    int cur_m [0:NP];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Marks m[0..NP-1] plus ruler length; the m[NP] field is filled with junk
    // because the recorder must take the last mark from val.
    task automatic set_ruler(input int a, input int b, input int c, input int d, input int e, input int v);
        cur_m[0] = a; cur_m[1] = b; cur_m[2] = c; cur_m[3] = d; cur_m[4] = e; cur_m[5] = v;
        val = 9'(v);
        for (int k = 0; k < NP; k++) begin
            marks_in[(NP + 1 - k) * 9 -: 9] = 9'(cur_m[k]);
        end
        marks_in[9:1] = 9'h1FF;
    endtask

    task automatic rand_ruler(input int v);
        set_ruler($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                  $urandom_range(0, 511), $urandom_range(0, 511), v);
    endtask

    task automatic model_reset();
        q_mark.delete();
        q_last.delete();
        m_limit = IL;
        m_sol   = 0;
        m_drop  = 0;
        m_done  = 0;
        m_exh   = 0;
    endtask

    task automatic model_step();
        if (m_done != 0) begin
            return;
        end
        if (q_mark.size() > 0) begin
            if (success) m_drop = 1;
            if (enabled == 7'd0) m_exh = 1;
            if (out_ready) begin
                void'(q_mark.pop_front());
                void'(q_last.pop_front());
                if (q_mark.size() == 0 && m_exh != 0) m_done = 1;
            end
        end else if (success && val != 0 && int'(val) <= m_limit) begin
            for (int k = 0; k <= NP; k++) begin
                q_mark.push_back(cur_m[k]);
                q_last.push_back(k == NP ? 1 : 0);
            end
            m_limit = int'(val) - 1;
            if (m_sol < 65535) m_sol++;
            m_exh = (enabled == 7'd0) ? 1 : 0;
        end else if (enabled == 7'd0) begin
            m_done = 1;
        end
    endtask

    task automatic check_outs();
        check_val("limit", 32'(limit), 32'(m_limit));
        check_val("hold", 32'(hold), 32'(q_mark.size() > 0));
        check_val("out_valid", 32'(out_valid), 32'(q_mark.size() > 0));
        check_val("solutions", 32'(solutions), 32'(m_sol));
        check_val("dropped", 32'(dropped), 32'(m_drop));
        check_val("done", 32'(done), 32'(m_done));
        if (q_mark.size() > 0) begin
            check_val("out_mark", 32'(out_mark), 32'(q_mark[0]));
            check_val("out_last", 32'(out_last), 32'(q_last[0]));
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_outs();
    endtask

    // Reset is raised between edges; the outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_limit", 32'(limit), 32'(IL));
        check_val("rst_hold", 32'(hold), 32'd0);
        check_val("rst_solutions", 32'(solutions), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_dropped", 32'(dropped), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        check_val("rst_out_mark", 32'(out_mark), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        success   = 1'b0;
        enabled   = 7'd3;
        out_ready = 1'b1;
        set_ruler(0, 0, 0, 0, 0, 0);
        do_reset();

        // Basic capture and full drain.
        set_ruler(0, 1, 4, 10, 12, 17);
        success = 1'b1;
        cycle();
        success = 1'b0;
        check_val("tp_limit16", 32'(limit), 32'd16);
        check_val("tp_first_mark", 32'(out_mark), 32'd0);
        repeat (6) cycle();
        check_val("tp_hold_released", 32'(hold), 32'd0);

        // Too long: ignored. Shorter: accepted.
        set_ruler(0, 2, 5, 9, 13, 18);
        success = 1'b1;
        cycle();
        check_val("tp_ignored_limit", 32'(limit), 32'd16);
        check_val("tp_ignored_sol", 32'(solutions), 32'd1);
        set_ruler(0, 1, 4, 10, 12, 16);
        cycle();
        success = 1'b0;
        check_val("tp_limit15", 32'(limit), 32'd15);

        // Backpressure at beat 2, then a success during the drain.
        repeat (2) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("bp_hold_mark", 32'(out_mark), 32'd4);
            check_val("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check_val("bp_resume_mark", 32'(out_mark), 32'd10);
        set_ruler(0, 1, 2, 3, 4, 5);
        success = 1'b1;
        cycle();
        success = 1'b0;
        check_val("drop_flag", 32'(dropped), 32'd1);
        check_val("drop_limit", 32'(limit), 32'd15);
        repeat (3) cycle();

        // Exhaustion in SEARCH.
        enabled = 7'd0;
        cycle();
        check_val("exh_done", 32'(done), 32'd1);
        enabled = 7'd3;
        repeat (2) cycle();
        do_reset();

        // Accept and exhaustion together: drain first, then done.
        set_ruler(0, 1, 4, 10, 12, 17);
        success = 1'b1;
        enabled = 7'd0;
        cycle();
        success = 1'b0;
        enabled = 7'd5;
        repeat (5) cycle();
        check_val("exh_pending_done", 32'(done), 32'd0);
        cycle();
        check_val("exh_after_drain", 32'(done), 32'd1);
        do_reset();

        // Reset in the middle of a drain.
        set_ruler(0, 1, 4, 10, 12, 17);
        success = 1'b1;
        cycle();
        success = 1'b0;
        repeat (3) cycle();
        check_val("mid_beat3", 32'(out_mark), 32'd10);
        do_reset();
        cycle();

        // val==0 ignored; val==1 drives limit to 0 and shuts everything out.
        set_ruler(0, 0, 0, 0, 0, 0);
        success = 1'b1;
        cycle();
        check_val("val0_ignored", 32'(solutions), 32'd0);
        set_ruler(0, 0, 0, 0, 0, 1);
        cycle();
        success = 1'b0;
        check_val("val1_limit", 32'(limit), 32'd0);
        repeat (6) cycle();
        set_ruler(0, 0, 0, 0, 0, 1);
        success = 1'b1;
        cycle();
        success = 1'b0;
        check_val("limit0_ignored", 32'(solutions), 32'd1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (m_done != 0 || (m_limit < 4 && q_mark.size() == 0 && $urandom_range(0, 9) == 0)
                || $urandom_range(0, 499) == 0) begin
                do_reset();
            end
            success   = ($urandom_range(0, 3) == 0);
            rand_ruler($urandom_range(0, 25));
            enabled   = ($urandom_range(0, 59) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/golomb_best_ruler_recorder.md
Name: golomb_best_ruler_recorder

Overview:
- Sits directly downstream of the last-mark (leaf) counter and the mark assembly.
- Consumes the leaf's success flag, its current value and the assembled mark vector.
- On each accepted ruler it latches the marks, tightens the shared length limit (fed back to every mark counter) and streams the marks out over a valid/ready port.
- Detects search exhaustion and raises done.

Parameters:
NUMPOSITIONS, 5, index of the last mark; the ruler has NUMPOSITIONS+1 marks, m[0]..m[NUMPOSITIONS].
INITLIMIT, 500, value loaded into limit on reset; the maximum ruler length still searched.

Ports:
clock  input  1  rising-edge system clock.
reset  input  1  asynchronous, active-high reset.
success  input  1  leaf reports a valid ruler ending at val this cycle.
val  input  9  leaf mark position (candidate ruler length).
enabled  input  7  currently active mark level; 0 means the search is exhausted.
marks_in  input  (NUMPOSITIONS+1)*9, indexed [((NUMPOSITIONS+1)*9):1]  packed marks. m[0] occupies the most significant 9 bits, m[k] occupies bits [((NUMPOSITIONS+1-k)*9):((NUMPOSITIONS-k)*9+1)].
limit  output  9  current maximum allowed length, fed to all mark counters.
hold  output  1  asks upstream counters to stall while a capture is being drained.
out_valid  output  1  out_mark is valid.
out_ready  input  1  consumer accepts out_mark this cycle.
out_mark  output  9  streamed mark value.
out_last  output  1  marks the final beat of a ruler (m[NUMPOSITIONS]).
solutions  output  16  number of accepted rulers; saturates at 16'hFFFF.
dropped  output  1  sticky: a success arrived while hold was high.
done  output  1  search exhausted and all output drained.

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - state=SEARCH, limit=INITLIMIT, hold=0, out_valid=0, out_mark=0, out_last=0, solutions=0, dropped=0, done=0.
  - Internal best[] cleared to 0; beat index cleared to 0.
- All inputs are sampled on the rising clock edge. All outputs are registered.
- Accept condition (SEARCH only): success=1 and val!=0 and val<=limit.
  - success with val==0 or val>limit is ignored; no counters change.
- State SEARCH:
  - On accept, in the same edge:
    - best[0..NUMPOSITIONS-1] <= marks_in fields m[0]..m[NUMPOSITIONS-1].
    - best[NUMPOSITIONS] <= val (the m[NUMPOSITIONS] field of marks_in is ignored).
    - limit <= val-1.
    - solutions increments, saturating.
    - hold <= 1, beat index <= 0, state <= DRAIN.
  - Else if enabled==0: state <= DONE, done <= 1.
  - Accept takes priority over enabled==0 when both occur in the same cycle; done is then entered after the drain.
- State DRAIN:
  - out_valid=1, out_mark=best[index], out_last=(index==NUMPOSITIONS).
  - The first beat is visible one cycle after the accept edge.
  - Beat transfer occurs when out_valid && out_ready; index then increments.
  - On transfer of the last beat:
    - out_valid <= 0, out_last <= 0, hold <= 0.
    - Next state is DONE if enabled==0 was seen at any point during the capture or drain; otherwise SEARCH.
  - out_mark, out_last and the index must stay stable while out_ready=0.
  - A success during DRAIN sets dropped=1 (sticky until reset) and is otherwise ignored; limit is not changed.
- State DONE:
  - done=1, hold=0, out_valid=0.
  - All inputs are ignored; the block remains in DONE until reset.
- limit is 9-bit unsigned and never wraps; the val!=0 guard guarantees val-1 >= 0.
  - val==1 accepted gives limit=0; every later success is then ignored.
- Reset asserted mid-drain immediately aborts the stream: out_valid drops asynchronously and limit returns to INITLIMIT.
- Latency: success to limit update is 1 cycle; success to first out_valid is 1 cycle; minimum drain is NUMPOSITIONS+1 cycles with out_ready held at 1.

Test Plan:
- NUMPOSITIONS=5, INITLIMIT=20, out_ready=1. success, val=17, marks m0..m4=0,1,4,10,12 → next cycle limit=16, hold=1, solutions=1. Beats 0,1,4,10,12,17 follow with out_last on 17, then hold=0.
- After the above, success val=18 in SEARCH → ignored: limit stays 16, solutions stays 1, no beats. success val=16 → accepted, limit=15.
- Backpressure: out_ready=0 for 3 cycles at beat 2 → out_mark holds at 4, out_valid stays 1, index does not advance. Raising out_ready resumes the stream with 10.
- success during DRAIN → dropped=1, limit and solutions unchanged, drain completes normally.
- enabled=0 in SEARCH → done=1 next cycle. enabled=0 and an accepted success in the same cycle → all 6 beats drain first, then done=1.
- Reset asserted mid-drain at beat 3 → out_valid=0 and limit=20 asynchronously. After release, state is SEARCH and solutions=0.
